smc_state_param: RTL
====================

Name: smc_state_param

Overview:
- Parametrised next-generation static-memory-controller sequencer. Serves multiple chip selects.
- Owns its own leading-edge, wait-state, trailing-edge and turnaround counters.
- Supports an external wait input and inserts bus-turnaround cycles when the chip select or the direction changes.
- Sits between the AHB interface and the multiple-access controller (MAC). It drives chip-select timing and the done/latch strobes.

Parameters:
NUM_CS, 4, number of chip selects (one-hot)
WS_W, 8, wait-state counter width
LE_W, 2, CS leading-edge counter width
TE_W, 2, CS trailing-edge (float) counter width
TA_W, 2, turnaround counter width

Ports:
sys_clk10  in  1  system clock
n_sys_reset10  in  1  asynchronous, active-low reset
new_access  in  1  valid access pending from AHB interface (held until accepted)
access_cs  in  NUM_CS  one-hot chip select of pending access
access_read  in  1  1 = read, 0 = write
t_csle  in  LE_W  leading-edge cycles
t_ws  in  WS_W  wait states per beat
t_cste  in  TE_W  trailing-edge (float) cycles
t_turn  in  TA_W  turnaround cycles on CS or direction change
mac_done  in  1  current beat is the last of the access
ext_wait_en  in  1  enable n_ext_wait sampling
n_ext_wait  in  1  active-low external wait
smc_state  out  3  current state
cs_out  out  NUM_CS  registered chip-select strobes (active high)
ws_count  out  WS_W  current wait counter
valid_access  out  1  access accepted this cycle (combinational)
beat_done  out  1  last cycle of an RW beat
latch_data  out  1  read data valid, latch this cycle
smc_done  out  1  last cycle of access
smc_idle  out  1  next state is IDLE

Behaviour:
- State encoding: IDLE=0, STORE=1, LE=2, RW=3, FLOAT=4, TURN=5. Codes 6 and 7 go to IDLE next cycle.
- Reset values: state IDLE, cs_out=0, all counters 0, stored cs/read/timings 0. At reset, smc_idle=1 and all other strobes are 0.
- Reset asserted mid-access: immediate return to IDLE and cs_out=0. The access is not completed.
- Acceptance point (AP): state IDLE, or the cycle in which smc_done=1.
- valid_access = new_access & AP.
- On valid_access, register access_cs, access_read and all t_* inputs. The inputs are not sampled again until the next acceptance.
- IDLE: if new_access, go to STORE; otherwise stay in IDLE.
- STORE (1 cycle): load le_cnt=t_csle and ws_cnt=t_ws. Go to LE if t_csle!=0, otherwise RW.
- LE: le_cnt decrements every cycle. Go to RW when le_cnt==1, so LE lasts exactly t_csle cycles.
- RW:
  - ws_cnt decrements every cycle until it reaches 0.
  - Hold condition: ws_cnt==0 & ext_wait_en & ~n_ext_wait. While held, stay in RW with ws_cnt=0.
  - Beat end is ws_cnt==0 and not held. A beat therefore lasts t_ws+1 cycles plus any held cycles.
  - At beat end, assert beat_done. Also assert latch_data if the stored access is a read.
  - Beat end with ~mac_done: reload ws_cnt=t_ws. If t_csle!=0, reload le_cnt and go to LE; otherwise stay in RW.
  - Beat end with mac_done: if t_cste!=0, load te_cnt=t_cste and go to FLOAT. Otherwise this cycle is the done cycle.
- FLOAT: te_cnt decrements. The cycle with te_cnt==1 is the done cycle, so FLOAT lasts t_cste cycles.
- Done cycle: assert smc_done. The next state is:
  - IDLE if ~new_access;
  - TURN if new_access, the new t_turn!=0, and (access_cs!=stored cs, or access_read!=stored read);
  - STORE otherwise.
- TURN: ta_cnt is loaded with the new t_turn. It decrements and goes to STORE when ta_cnt==1.
- cs_out = stored cs in STORE, LE, RW and FLOAT; 0 in IDLE and TURN.
- Back-to-back access to the same CS in the same direction: cs_out stays asserted with no gap.
- new_access outside an AP is ignored. valid_access=0 and the requester holds.
- Counters never wrap. ws_cnt saturates at 0.
- smc_idle = (next state == IDLE).

Test Plan:
- Single read, t_csle=0, t_ws=2, t_cste=0, mac_done=1. Required: states STORE,RW,RW,RW. latch_data, beat_done and smc_done all on the 3rd RW cycle. cs_out asserted for 4 cycles, then IDLE.
- Write, t_csle=2, t_ws=1, t_cste=2. Required: STORE,LE,LE,RW,RW,FLOAT,FLOAT. smc_done on the 2nd FLOAT. latch_data is never asserted.
- 3-beat read (mac_done=1 only on 3rd beat), t_csle=1, t_ws=0. Required: LE,RW repeated 3 times. beat_done pulses 3 times and smc_done once.
- ext_wait_en=1, n_ext_wait low for 4 cycles from the first RW cycle, t_ws=1. Required: RW lasts 5 cycles. ws_count is 0 while held. beat_done fires only after n_ext_wait rises.
- Back-to-back: read CS0 followed by write CS1 with t_turn=2. Required: valid_access in the done cycle, then TURN 2 cycles with cs_out=0, then STORE with cs_out=0010. Repeating with the same CS and direction gives STORE directly with cs_out held continuously.
- Reset asserted during RW with ws_count=5. Required: state 0 and cs_out=0 immediately. After reset release, smc_idle=1 and no strobes are asserted.

Source files
------------

// File: rtl/smc_state_param.sv
// Static-memory-controller access sequencer: chip-select leading edge, wait states,
// trailing-edge float and bus turnaround between accesses handed over by the AHB interface.
module smc_state_param #(
  parameter int NUM_CS = 4,
  parameter int WS_W   = 8,
  parameter int LE_W   = 2,
  parameter int TE_W   = 2,
  parameter int TA_W   = 2
) (
  input  logic              sys_clk10,
  input  logic              n_sys_reset10,
  input  logic              new_access,
  input  logic [NUM_CS-1:0] access_cs,
  input  logic              access_read,
  input  logic [LE_W-1:0]   t_csle,
  input  logic [WS_W-1:0]   t_ws,
  input  logic [TE_W-1:0]   t_cste,
  input  logic [TA_W-1:0]   t_turn,
  input  logic              mac_done,
  input  logic              ext_wait_en,
  input  logic              n_ext_wait,
  output logic [2:0]        smc_state,
  output logic [NUM_CS-1:0] cs_out,
  output logic [WS_W-1:0]   ws_count,
  output logic              valid_access,
  output logic              beat_done,
  output logic              latch_data,
  output logic              smc_done,
  output logic              smc_idle
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_LE    = 3'd2,
    ST_RW    = 3'd3,
    ST_FLOAT = 3'd4,
    ST_TURN  = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [NUM_CS-1:0] cs_reg, next_cs, cs_out_nxt;
  logic              read_reg;
  logic [LE_W-1:0]   csle_reg, le_cnt, le_nxt;
  logic [WS_W-1:0]   ws_reg, ws_cnt, ws_nxt;
  logic [TE_W-1:0]   cste_reg, te_cnt, te_nxt;
  logic [TA_W-1:0]   ta_cnt, ta_nxt;
  logic              accept_point;

  always_comb begin
    next_state = state;
    le_nxt     = le_cnt;
    ws_nxt     = ws_cnt;
    te_nxt     = te_cnt;
    ta_nxt     = ta_cnt;
    beat_done  = 1'b0;
    latch_data = 1'b0;
    smc_done   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (new_access) next_state = ST_STORE;
      end
      ST_STORE: begin
        le_nxt     = csle_reg;
        ws_nxt     = ws_reg;
        next_state = (csle_reg != '0) ? ST_LE : ST_RW;
      end
      ST_LE: begin
        if (le_cnt != '0) le_nxt = le_cnt - LE_W'(1);
        if (le_cnt <= LE_W'(1)) next_state = ST_RW;
      end
      ST_RW: begin
        // Held cycles (external wait with the counter already at zero) just leave everything as is
        if (ws_cnt != '0) begin
          ws_nxt = ws_cnt - WS_W'(1);
        end else if (!(ext_wait_en && !n_ext_wait)) begin
          beat_done  = 1'b1;
          latch_data = read_reg;
          if (!mac_done) begin
            ws_nxt = ws_reg;
            if (csle_reg != '0) begin
              le_nxt     = csle_reg;
              next_state = ST_LE;
            end
          end else if (cste_reg != '0) begin
            te_nxt     = cste_reg;
            next_state = ST_FLOAT;
          end else begin
            smc_done = 1'b1;
          end
        end
      end
      ST_FLOAT: begin
        if (te_cnt != '0) te_nxt = te_cnt - TE_W'(1);
        if (te_cnt <= TE_W'(1)) smc_done = 1'b1;
      end
      ST_TURN: begin
        if (ta_cnt != '0) ta_nxt = ta_cnt - TA_W'(1);
        if (ta_cnt <= TA_W'(1)) next_state = ST_STORE;
      end
      default: next_state = ST_IDLE;
    endcase

    // The done cycle doubles as an acceptance point, so a follow-on access chains straight on
    if (smc_done) begin
      if (!new_access) begin
        next_state = ST_IDLE;
      end else if ((t_turn != '0) && ((access_cs != cs_reg) || (access_read != read_reg))) begin
        next_state = ST_TURN;
        ta_nxt     = t_turn;
      end else begin
        next_state = ST_STORE;
      end
    end
  end

  always_comb begin
    accept_point = (state == ST_IDLE) || smc_done;
    valid_access = new_access && accept_point;
    smc_idle     = (next_state == ST_IDLE);
    next_cs      = valid_access ? access_cs : cs_reg;
    cs_out_nxt   = '0;
    if ((next_state == ST_STORE) || (next_state == ST_LE) ||
        (next_state == ST_RW)    || (next_state == ST_FLOAT))
      cs_out_nxt = next_cs;
  end

  always_ff @(posedge sys_clk10 or negedge n_sys_reset10) begin
    if (!n_sys_reset10) begin
      state    <= ST_IDLE;
      cs_out   <= '0;
      cs_reg   <= '0;
      read_reg <= 1'b0;
      csle_reg <= '0;
      ws_reg   <= '0;
      cste_reg <= '0;
      le_cnt   <= '0;
      ws_cnt   <= '0;
      te_cnt   <= '0;
      ta_cnt   <= '0;
    end else begin
      state  <= next_state;
      cs_out <= cs_out_nxt;
      le_cnt <= le_nxt;
      ws_cnt <= ws_nxt;
      te_cnt <= te_nxt;
      ta_cnt <= ta_nxt;
      if (valid_access) begin
        cs_reg   <= access_cs;
        read_reg <= access_read;
        csle_reg <= t_csle;
        ws_reg   <= t_ws;
        cste_reg <= t_cste;
      end
    end
  end

  assign smc_state = state;
  assign ws_count  = ws_cnt;

endmodule
